// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch sequencer
// Contents: fetch state enum, NOP encoding, {pc, instr} FIFO entry, range check.
package fetch_pkg;

  typedef enum logic [1:0] {RUN, HALTED, FAULT} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // True when the word index of pc falls inside implemented memory
  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned words);
    return {2'b00, pc[31:2]} < words;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetched {pc, instr} pairs
// Ports: clk/rst; push/pop/flush requests; din entry in; full/empty flags;
// head = entry at read pointer, zero when empty. Flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and fetch sequencer feeding decode through a small FIFO
// Ports: clk/rst; imem_a/imem_rst/imem_rd to the combinational instruction memory;
// halt and redirect_valid/redirect_pc control; valid_o/ready_i/instr_o/pc_o to decode;
// fault_o sticky while the PC is outside implemented memory.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_a,
  output logic        imem_rst,
  input  logic [31:0] imem_rd,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);
  fetch_state_e state, state_next;
  logic [31:0] pc, pc_next, target;
  logic pc_ok, push, pop, full, empty;
  fetch_entry_t head;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din('{pc: pc, instr: imem_rd}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
    end else begin
      state <= state_next;
      pc <= pc_next;
    end
  end
  always_comb begin
    target = redirect_pc & ~32'h3;
    pc_ok = pc_in_range(pc, IMEM_WORDS);
    pop = !empty && ready_i;
    // Out-of-range PCs are never pushed, even for the one cycle before FAULT is entered
    push = state == RUN && !redirect_valid && pc_ok && (!full || pop);
    pc_next = redirect_valid ? target : push ? pc + 32'd4 : pc;
    state_next = state;
    if (redirect_valid) state_next = pc_in_range(target, IMEM_WORDS) ? RUN : FAULT;
    else if (state != FAULT && !pc_ok) state_next = FAULT;
    else if (state == RUN && halt) state_next = HALTED;
    else if (state == HALTED && !halt) state_next = RUN;
  end
  assign imem_a = pc;
  assign imem_rst = rst;
  assign valid_o = !empty;
  assign instr_o = head.instr;
  assign pc_o = head.pc;
  assign fault_o = state == FAULT;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and random stimulus against a queue-based fetch model
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int DEPTH = 2;
  localparam int WORDS = 1024;

  logic clk = 0, rst = 1, halt = 0, redirect_valid = 0, ready_i = 0;
  logic [31:0] redirect_pc = 0, imem_a, imem_rd, instr_o, pc_o;
  logic imem_rst, valid_o, fault_o;
  logic [31:0] mem [WORDS];
  int vectors = 0, errors = 0;

  fetch_entry_t q[$];
  logic [31:0] m_pc;
  bit m_halted, m_fault;

  always #5 clk = ~clk;

  assign imem_rd = imem_rst ? 32'h0 : mem[imem_a[11:2]];

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .IMEM_WORDS(WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .imem_a(imem_a),
    .imem_rst(imem_rst),
    .imem_rd(imem_rd),
    .halt(halt),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .fault_o(fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one clock edge given the inputs held during the cycle
  task automatic model_step(input bit r, input bit h, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit popped, fetch, old_ok;
    if (r) begin
      m_pc = RESET_PC;
      q.delete();
      m_halted = 0;
      m_fault = 0;
      return;
    end
    if (rv) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_fault = rpc[31:2] >= WORDS;
      m_halted = 0;
      return;
    end
    popped = q.size() > 0 && rdy;
    old_ok = m_pc[31:2] < WORDS;
    fetch = !m_fault && !m_halted && old_ok && (q.size() < DEPTH || popped);
    if (popped) void'(q.pop_front());
    if (fetch) begin
      q.push_back('{pc: m_pc, instr: mem[m_pc[11:2]]});
      m_pc = m_pc + 4;
    end
    if (!m_fault) begin
      if (!old_ok) m_fault = 1;
      else m_halted = h;
    end
  endtask

  task automatic cycle(input bit r, input bit h, input bit rv, input logic [31:0] rpc, input bit rdy);
    rst = r;
    halt = h;
    redirect_valid = rv;
    redirect_pc = rpc;
    ready_i = rdy;
    model_step(r, h, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    chk("valid_o", {31'b0, valid_o}, {31'b0, q.size() > 0});
    chk("pc_o", pc_o, q.size() > 0 ? q[0].pc : 32'h0);
    chk("instr_o", instr_o, q.size() > 0 ? q[0].instr : 32'h0);
    chk("fault_o", {31'b0, fault_o}, {31'b0, m_fault});
    chk("imem_a", imem_a, m_pc);
  endtask

  task automatic run(input int n, input bit h, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, h, 0, 32'h0, rdy);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00300113;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h0000006F;
    @(negedge clk);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_imem_a", imem_a, RESET_PC);
    chk("imem_rst", {31'b0, imem_rst}, 32'h1);
    run(1, 0, 1);
    chk("first_pc", pc_o, 32'h0);
    chk("first_instr", instr_o, 32'h00500093);
    run(1, 0, 1);
    chk("second_instr", instr_o, 32'h00300113);
    run(2, 0, 1);
    chk("fourth_pc", pc_o, 32'hC);
    cycle(1, 0, 0, 0, 0);
    run(6, 0, 0);
    chk("stall_head", pc_o, 32'h0);
    chk("stall_pc", imem_a, 32'h8);
    run(4, 0, 1);
    cycle(0, 0, 1, 32'h43, 0);
    chk("redir_bubble", {31'b0, valid_o}, 32'h0);
    run(1, 0, 1);
    chk("redir_pc", pc_o, 32'h40);
    run(3, 1, 1);
    chk("halt_drained", {31'b0, valid_o}, 32'h0);
    run(4, 0, 1);
    cycle(0, 0, 1, 32'hFFC, 1);
    run(1, 0, 1);
    chk("last_word", pc_o, 32'hFFC);
    run(3, 0, 1);
    chk("fault_set", {31'b0, fault_o}, 32'h1);
    chk("fault_empty", {31'b0, valid_o}, 32'h0);
    cycle(0, 0, 1, 32'h0, 1);
    chk("fault_clr", {31'b0, fault_o}, 32'h0);
    run(3, 0, 1);
    run(4, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("mid_rst_valid", {31'b0, valid_o}, 32'h0);
    chk("mid_rst_pc", imem_a, RESET_PC);
    cycle(0, 0, 1, 32'h2000, 1);
    chk("oor_redirect", {31'b0, fault_o}, 32'h1);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 1100) * 4 + $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
